// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
//   Shared definitions for the Morse letter decoder (letters S..Z):
//   letter codes, symbol encoding, FSM state type and the letter lookup table.
//   No ports.
// -----------------------------------------------------------------------------
package morse_pkg;

    // Letter codes reported on the letter output
    localparam logic [2:0] L_S = 3'd0;
    localparam logic [2:0] L_T = 3'd1;
    localparam logic [2:0] L_U = 3'd2;
    localparam logic [2:0] L_V = 3'd3;
    localparam logic [2:0] L_W = 3'd4;
    localparam logic [2:0] L_X = 3'd5;
    localparam logic [2:0] L_Y = 3'd6;
    localparam logic [2:0] L_Z = 3'd7;

    // Symbol encoding inside the shift register
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    // Table patterns are MSB-first, right-aligned in TABLE_W bits.
    localparam int TABLE_W   = 4;
    localparam int N_LETTERS = 8;

    localparam int unsigned TBL_CNT [N_LETTERS] = '{3, 1, 3, 4, 3, 4, 4, 4};
    localparam logic [TABLE_W-1:0] TBL_PAT [N_LETTERS] = '{
        4'b0000,   // S ...
        4'b0001,   // T -
        4'b0001,   // U ..-
        4'b0001,   // V ...-
        4'b0011,   // W .--
        4'b1001,   // X -..-
        4'b1011,   // Y -.--
        4'b1100    // Z --..
    };

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } lookup_t;

    // Count and pattern must both match; several letters share a pattern
    // and differ only in symbol count.
    function automatic lookup_t lookup(input int unsigned cnt,
                                       input logic [TABLE_W-1:0] pat);
        lookup_t r;
        r.hit  = 1'b0;
        r.code = L_S;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (cnt == TBL_CNT[i] && pat == TBL_PAT[i]) begin
                r.hit  = 1'b1;
                r.code = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_decoder_tick_gen.sv
// -----------------------------------------------------------------------------
// morse_tick_gen
//   Free-running symbol-period down-counter. Emits tick for one clk when the
//   count is zero, then reloads TICK_DIV-1. realign reloads TICK_DIV/2 so the
//   following samples land inside each bit after a line rising edge.
// Ports
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (count loads TICK_DIV-1)
//   realign  in  load the half-period value this clk
//   tick     out one-clk sample strobe
// -----------------------------------------------------------------------------
module morse_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic realign,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF   = CW'(TICK_DIV / 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RELOAD;
        end else if (realign) begin
            count <= HALF;
        end else if (count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
//   Recovers the 3-bit letter code (S..Z) from a serial Morse line carrying
//   one bit per symbol period. The line is sampled once per period, mark and
//   space runs are measured, symbols are classified and, after a letter gap,
//   the letter is looked up and reported (valid) or discarded (err).
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   in       in   serial Morse line, 1 = mark
//   letter   out  [2:0] last decoded letter, held until the next valid
//   valid    out  one-clk pulse, letter updated
//   err      out  one-clk pulse, malformed letter discarded
//   busy     out  high from the first sampled mark until the letter ends
// Build option
//   MORSE_DEC_SYNC_EN: route in through a 2-flop synchroniser first.
//   Undefined: in must already be synchronous to clk.
// Handshake: valid and err are mutually exclusive single-cycle pulses with no
//   back-pressure; letter is stable whenever valid is high and afterwards.
// -----------------------------------------------------------------------------
module morse_decoder #(
    parameter int TICK_DIV = 25000000,
    parameter int MAX_SYM  = 4,
    parameter int GAP_BITS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in,
    output logic [2:0] letter,
    output logic       valid,
    output logic       err,
    output logic       busy
);
    import morse_pkg::*;

    localparam int SCW = $clog2(MAX_SYM + 1);

    logic line;
    logic line_d;

`ifdef MORSE_DEC_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], in};
    end
    assign line = sync_q[1];
`else
    assign line = in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) line_d <= 1'b0;
        else          line_d <= line;
    end

    state_t             state, state_n;
    logic [2:0]         mark_cnt, mark_cnt_n;
    logic [1:0]         space_cnt, space_cnt_n;
    logic [MAX_SYM-1:0] sym, sym_n;
    logic [SCW-1:0]     sym_cnt, sym_cnt_n;
    logic               bad, bad_n;
    logic [2:0]         letter_n;
    logic               valid_n, err_n, busy_n;

    logic    tick;
    logic    realign;
    logic    step;
    logic    sym_bit;
    logic    mark_ok;
    lookup_t found;

    // Rising edge while idle re-phases the sampler. The tick that may
    // coincide with that edge is dropped so the new first bit is sampled
    // once, from the realigned phase.
    assign realign = (state == ST_IDLE) && line && !line_d;
    assign step    = tick && !realign;

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .realign (realign),
        .tick    (tick)
    );

    assign sym_bit = (mark_cnt == 3'd3) ? SYM_DASH : SYM_DOT;
    assign mark_ok = (mark_cnt == 3'd1) || (mark_cnt == 3'd3);
    assign found   = lookup(int'(sym_cnt), TABLE_W'(sym));

    always_comb begin
        state_n     = state;
        mark_cnt_n  = mark_cnt;
        space_cnt_n = space_cnt;
        sym_n       = sym;
        sym_cnt_n   = sym_cnt;
        bad_n       = bad;
        letter_n    = letter;
        valid_n     = 1'b0;
        err_n       = 1'b0;
        busy_n      = busy;

        case (state)
            ST_IDLE: begin
                if (step && line) begin
                    state_n    = ST_MARK;
                    mark_cnt_n = 3'd1;
                    busy_n     = 1'b1;
                end
            end

            ST_MARK: begin
                if (step) begin
                    if (line) begin
                        if (mark_cnt != 3'd7) mark_cnt_n = mark_cnt + 3'd1;
                    end else begin
                        if (!mark_ok) bad_n = 1'b1;
                        sym_n = MAX_SYM'({sym, sym_bit});
                        if (int'(sym_cnt) == MAX_SYM) bad_n = 1'b1;
                        else                          sym_cnt_n = sym_cnt + SCW'(1);
                        state_n     = ST_SPACE;
                        space_cnt_n = 2'd1;
                    end
                end
            end

            ST_SPACE: begin
                if (step) begin
                    if (line) begin
                        // One zero separates symbols; two is a malformed gap.
                        if (space_cnt >= 2'd2) bad_n = 1'b1;
                        state_n    = ST_MARK;
                        mark_cnt_n = 3'd1;
                    end else if (int'(space_cnt) + 1 >= GAP_BITS) begin
                        if (found.hit && !bad) begin
                            letter_n = found.code;
                            valid_n  = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                        sym_n       = '0;
                        sym_cnt_n   = '0;
                        bad_n       = 1'b0;
                        mark_cnt_n  = '0;
                        space_cnt_n = '0;
                        busy_n      = 1'b0;
                        state_n     = ST_IDLE;
                    end else if (space_cnt != 2'd3) begin
                        space_cnt_n = space_cnt + 2'd1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mark_cnt  <= '0;
            space_cnt <= '0;
            sym       <= '0;
            sym_cnt   <= '0;
            bad       <= 1'b0;
            letter    <= L_S;
            valid     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            mark_cnt  <= mark_cnt_n;
            space_cnt <= space_cnt_n;
            sym       <= sym_n;
            sym_cnt   <= sym_cnt_n;
            bad       <= bad_n;
            letter    <= letter_n;
            valid     <= valid_n;
            err       <= err_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder
//   Directed bench for morse_decoder with TICK_DIV=4: each Morse bit is held
//   for 4 clk. A monitor counts valid/err pulses and protocol violations;
//   each scenario task checks its own expectations.
// -----------------------------------------------------------------------------
module tb_morse_decoder;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_line = 1'b0;
    logic [2:0] letter;
    logic       valid;
    logic       err;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    int valid_cnt = 0;
    int err_cnt = 0;
    int busy_cycles = 0;
    int viol_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    morse_decoder #(.TICK_DIV(TICK_DIV), .MAX_SYM(4), .GAP_BITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in_line),
        .letter  (letter),
        .valid   (valid),
        .err     (err),
        .busy    (busy)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, run did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (valid) valid_cnt++;
            if (err) err_cnt++;
            if (busy) busy_cycles++;
            if (valid && err) viol_cnt++;
            if ((valid || err) && busy) viol_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        in_line = b;
        repeat (TICK_DIV) @(negedge clk);
    endtask

    task automatic send_bits(input string s);
        for (int i = 0; i < s.len(); i++) send_bit(s[i] == 8'h31);
    endtask

    task automatic idle_clks(input int n);
        in_line = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        err_cnt = 0;
        busy_cycles = 0;
        viol_cnt = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        in_line = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (letter !== 3'd0) begin tests_failed++; $display("FAIL reset_letter: got %0d want 0", letter); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_line();
        clear_counts();
        idle_clks(40);
        tests_run++; if (valid_cnt !== 0) begin tests_failed++; $display("FAIL idle_valid: got %0d pulses want 0", valid_cnt); end
        tests_run++; if (err_cnt !== 0) begin tests_failed++; $display("FAIL idle_err: got %0d pulses want 0", err_cnt); end
        tests_run++; if (busy_cycles !== 0) begin tests_failed++; $display("FAIL idle_busy: got %0d busy cycles want 0", busy_cycles); end
    endtask

    task automatic test_letter_s();
        clear_counts();
        send_bits("101");
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL s_busy_mid: got %b want 1", busy); end
        send_bits("01000");
        idle_clks(8);
        tests_run++; if (valid_cnt !== 1) begin tests_failed++; $display("FAIL s_valid_count: got %0d want 1", valid_cnt); end
        tests_run++; if (err_cnt !== 0) begin tests_failed++; $display("FAIL s_err_count: got %0d want 0", err_cnt); end
        tests_run++; if (letter !== 3'd0) begin tests_failed++; $display("FAIL s_letter: got %0d want 0", letter); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL s_busy_end: got %b want 0", busy); end
        tests_run++; if (viol_cnt !== 0) begin tests_failed++; $display("FAIL s_protocol: got %0d violations want 0", viol_cnt); end
    endtask

    task automatic test_t_then_z();
        clear_counts();
        send_bits("111000");
        idle_clks(8);
        tests_run++; if (letter !== 3'd1) begin tests_failed++; $display("FAIL t_letter: got %0d want 1", letter); end
        send_bits("1110111010100000");
        idle_clks(8);
        tests_run++; if (letter !== 3'd7) begin tests_failed++; $display("FAIL z_letter: got %0d want 7", letter); end
        tests_run++; if (valid_cnt !== 2) begin tests_failed++; $display("FAIL tz_valid_count: got %0d want 2", valid_cnt); end
        tests_run++; if (err_cnt !== 0) begin tests_failed++; $display("FAIL tz_err_count: got %0d want 0", err_cnt); end
        tests_run++; if (viol_cnt !== 0) begin tests_failed++; $display("FAIL tz_protocol: got %0d violations want 0", viol_cnt); end
    endtask

    task automatic test_errors();
        // two-bit mark
        clear_counts();
        send_bits("11000");
        idle_clks(8);
        tests_run++; if (err_cnt !== 1) begin tests_failed++; $display("FAIL short_mark_err: got %0d want 1", err_cnt); end
        tests_run++; if (valid_cnt !== 0) begin tests_failed++; $display("FAIL short_mark_valid: got %0d want 0", valid_cnt); end
        tests_run++; if (letter !== 3'd7) begin tests_failed++; $display("FAIL short_mark_letter: got %0d want 7", letter); end
        // five symbols
        clear_counts();
        send_bits("101010101000");
        idle_clks(8);
        tests_run++; if (err_cnt !== 1) begin tests_failed++; $display("FAIL five_dots_err: got %0d want 1", err_cnt); end
        tests_run++; if (valid_cnt !== 0) begin tests_failed++; $display("FAIL five_dots_valid: got %0d want 0", valid_cnt); end
        // two-zero gap inside a letter
        clear_counts();
        send_bits("1001000");
        idle_clks(8);
        tests_run++; if (err_cnt !== 1) begin tests_failed++; $display("FAIL gap2_err: got %0d want 1", err_cnt); end
        tests_run++; if (valid_cnt !== 0) begin tests_failed++; $display("FAIL gap2_valid: got %0d want 0", valid_cnt); end
        tests_run++; if (viol_cnt !== 0) begin tests_failed++; $display("FAIL err_protocol: got %0d violations want 0", viol_cnt); end
        tests_run++; if (letter !== 3'd7) begin tests_failed++; $display("FAIL err_letter_hold: got %0d want 7", letter); end
    endtask

    task automatic test_reset_mid_letter();
        clear_counts();
        send_bits("10111");
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset_n = 1'b0;
        in_line = 1'b0;
        @(negedge clk);
        tests_run++; if (letter !== 3'd0) begin tests_failed++; $display("FAIL mid_reset_letter: got %0d want 0", letter); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        idle_clks(16);
        tests_run++; if (valid_cnt !== 0 || err_cnt !== 0) begin tests_failed++; $display("FAIL mid_reset_pulses: got valid=%0d err=%0d want 0/0", valid_cnt, err_cnt); end
        send_bits("1011101110000");
        idle_clks(8);
        tests_run++; if (letter !== 3'd4) begin tests_failed++; $display("FAIL w_letter: got %0d want 4", letter); end
        tests_run++; if (valid_cnt !== 1) begin tests_failed++; $display("FAIL w_valid_count: got %0d want 1", valid_cnt); end
    endtask

    task automatic test_phase_offset();
        for (int off = 1; off <= 3; off++) begin
            clear_counts();
            idle_clks(off);
            send_bits("10101000");
            idle_clks(8 + off);
            tests_run++; if (letter !== 3'd0) begin tests_failed++; $display("FAIL off%0d_s: got %0d want 0", off, letter); end
            send_bits("111000");
            idle_clks(5);
            tests_run++; if (letter !== 3'd1) begin tests_failed++; $display("FAIL off%0d_t: got %0d want 1", off, letter); end
            send_bits("1110111010100000");
            idle_clks(7);
            tests_run++; if (letter !== 3'd7) begin tests_failed++; $display("FAIL off%0d_z: got %0d want 7", off, letter); end
            tests_run++; if (valid_cnt !== 3 || err_cnt !== 0) begin tests_failed++; $display("FAIL off%0d_pulses: got valid=%0d err=%0d want 3/0", off, valid_cnt, err_cnt); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_idle_line();
        test_letter_s();
        test_t_then_z();
        test_errors();
        test_reset_mid_letter();
        test_phase_offset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
